uart_rx_core: RTL and testbench

Oversampling UART receiver that consumes the 16x tick from the baud generator. It deserialises one asynchronous frame from the rx pin: start bit, DATA_BITS data bits LSB-first, an optional parity bit, and one stop bit. It presents the received word with a one-cycle valid strobe and per-frame error flags to the downstream host/FIFO logic.

---
 rtl/uart_rx_core.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : 16x-oversampling UART receiver. Detects the start bit, samples
//            each data bit (LSB first), an optional parity bit and one stop
//            bit at mid-bit, then presents the word with a one-clk valid
//            strobe and per-frame framing/parity error flags.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            baud_rx           - one-clk tick at OVERSAMPLE x baud rate
//            rx                - asynchronous serial input, idle high
//            parity_en         - frame carries a parity bit
//            parity_odd        - 1 = odd parity, 0 = even parity
//            data_out          - last received word
//            data_valid        - one-clk pulse when data_out/flags update
//            framing_err       - stop bit of last frame sampled low
//            parity_err        - parity mismatch on last frame
//            busy              - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_rx,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);

    localparam logic [SCNT_W-1:0] C_HALF     = SCNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [SCNT_W-1:0] C_FULL     = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        C_LAST_BIT = 3'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [SCNT_W-1:0]    r_s_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_par_bit;
    logic                 w_at_half;
    logic                 w_at_full;
    logic                 w_par_exp;

    assign w_at_half = (r_s_cnt == C_HALF);
    assign w_at_full = (r_s_cnt == C_FULL);
    // Even parity expects the XOR of the data bits; odd parity inverts it.
    assign w_par_exp = (^r_shreg) ^ r_par_odd;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: every transition is gated by the oversample tick.
    always_comb begin
        w_next_state = r_state;
        if (baud_rx) begin
            case (r_state)
                S_IDLE:   if (!r_rx_s) w_next_state = S_START;
                S_START:  if (w_at_half) w_next_state = r_rx_s ? S_IDLE : S_DATA;
                S_DATA:   if (w_at_full && (r_bit_cnt == C_LAST_BIT))
                              w_next_state = r_par_en ? S_PARITY : S_STOP;
                S_PARITY: if (w_at_full) w_next_state = S_STOP;
                // Leave at stop mid-bit so an immediately following start
                // edge is still caught.
                S_STOP:   if (w_at_full) w_next_state = S_IDLE;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // Counters, shift register and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_cnt     <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_par_bit   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (baud_rx) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_s) r_s_cnt <= '0;
                    end
                    S_START: begin
                        if (w_at_half) begin
                            r_s_cnt <= '0;
                            if (!r_rx_s) begin
                                r_bit_cnt <= '0;
                                // Frame format is frozen for the whole frame.
                                r_par_en  <= parity_en;
                                r_par_odd <= parity_odd;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + SCNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_at_full) begin
                            // LSB arrives first, so after DATA_BITS shifts the
                            // word is right-aligned.
                            r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_s_cnt <= '0;
                            if (r_bit_cnt != C_LAST_BIT)
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else begin
                            r_s_cnt <= r_s_cnt + SCNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (w_at_full) begin
                            r_par_bit <= r_rx_s;
                            r_s_cnt   <= '0;
                        end else begin
                            r_s_cnt <= r_s_cnt + SCNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_at_full) begin
                            data_out    <= r_shreg;
                            framing_err <= ~r_rx_s;
                            parity_err  <= r_par_en & (r_par_bit != w_par_exp);
                            data_valid  <= 1'b1;
                            r_s_cnt     <= '0;
                        end else begin
                            r_s_cnt <= r_s_cnt + SCNT_W'(1);
                        end
                    end
                    default: r_s_cnt <= '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Self-checking bench for uart_rx_core. Stimulus pushes the
//            expected word/flags into a scoreboard queue; a monitor pops and
//            compares on every data_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_rx = 1'b0;
    logic       rx = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       parity_err;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    exp_t sb_q[$];
    int   valid_ticks[$];
    int   tick_cnt = 0;
    int   baud_div = 0;
    logic prev_valid = 1'b0;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_rx    (baud_rx),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .framing_err(framing_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One tick every 27 clks, changed on the falling edge so it is stable
    // around the rising edge the DUT samples on.
    always @(negedge clk) begin
        baud_div <= (baud_div == 26) ? 0 : baud_div + 1;
        baud_rx  <= (baud_div == 26);
    end

    always @(posedge clk) if (baud_rx) tick_cnt <= tick_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (data_valid) begin
            exp_t e;
            valid_ticks.push_back(tick_cnt);
            compared++;
            if (prev_valid) begin
                mismatched++;
                $display("FAIL valid_width: data_valid high for 2+ clks");
            end
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid: data_out=0x%0h with no frame expected", data_out);
            end else begin
                e = sb_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("framing_err", 32'(framing_err), 32'(e.fe));
                check("parity_err", 32'(parity_err), 32'(e.pe));
            end
        end
        prev_valid <= data_valid;
    end

    // Returns just after the rising edge that consumed a tick.
    task automatic wait_tick();
        do @(negedge clk); while (!baud_rx);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d; e.fe = fe; e.pe = pe;
        sb_q.push_back(e);
    endtask

    // Bounded drain: every expected frame must have been popped.
    task automatic drain(input string name);
        repeat (4) wait_tick();
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] frame5a;
        frame5a = 8'h5A;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_fe", 32'(framing_err), 32'd0);
        check("rst_pe", 32'(parity_err), 32'd0);
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) wait_tick();

        // Reset asserted in the middle of the data bits of 0x5A
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(frame5a[i]);
        check("busy_mid_frame", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(data_valid), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) wait_tick();

        expect_frame(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        drain("drain_c3");

        // 8N1 0xA5
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        drain("drain_a5");
        check("busy_after_a5", 32'(busy), 32'd0);

        // False start: low for 3 ticks, then back high
        rx = 1'b0;
        repeat (3) wait_tick();
        rx = 1'b1;
        repeat (20) wait_tick();
        check("false_start_busy", 32'(busy), 32'd0);
        check("false_start_data", 32'(data_out), 32'hA5);

        // Framing error: stop bit driven low
        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20) wait_tick();
        check("drain_3c", 32'(sb_q.size()), 32'd0);
        check("busy_after_fe", 32'(busy), 32'd0);

        // Parity: 0x81 has two ones, so even parity bit is 0, odd is 1
        parity_en = 1'b1; parity_odd = 1'b0;
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        drain("drain_even_ok");
        expect_frame(8'h81, 1'b0, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        drain("drain_even_bad");
        parity_odd = 1'b1;
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        drain("drain_odd_ok");
        parity_en = 1'b0; parity_odd = 1'b0;
        repeat (3) wait_tick();

        // Back-to-back frames, no idle gap
        expect_frame(8'h00, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        drain("drain_b2b");
        if (valid_ticks.size() >= 2)
            check("b2b_spacing", 32'(valid_ticks[$] - valid_ticks[$-1]), 32'd160);
        else
            check("b2b_pulses", 32'(valid_ticks.size()), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog
    initial begin
        #20_000_000;
        $display("FAIL watchdog: timeout, compared=%0d", compared);
        $fatal(1);
    end

endmodule
`default_nettype wire
